// File: rtl/bus_arbiter_mux.sv
// ============================================================================
//  Module      : bus_arbiter_mux
//  Description : Two-master bus arbiter with fixed M0 priority from IDLE and
//                hold-while-requesting grants. It muxes the granted master's
//                write strobe, address and write data onto the slave bus.
//                The optional macro BUS_ARB_TIMEOUT_EN adds forced handover
//                after MAX_HOLD consecutive grant cycles when the other
//                master is waiting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_mux #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  M0_req,
    input  logic                  M0_wr,
    input  logic [ADDR_WIDTH-1:0] M0_address,
    input  logic [DATA_WIDTH-1:0] M0_dout,
    input  logic                  M1_req,
    input  logic                  M1_wr,
    input  logic [ADDR_WIDTH-1:0] M1_address,
    input  logic [DATA_WIDTH-1:0] M1_dout,
    output logic                  M0_grant,
    output logic                  M1_grant,
    output logic                  S_wr,
    output logic [ADDR_WIDTH-1:0] S_address,
    output logic [DATA_WIDTH-1:0] S_din,
    output logic                  bus_busy
);

    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_GNT0 = 2'b01;
    localparam logic [1:0] c_GNT1 = 2'b10;

    // The hold counter is 8 bits wide, so MAX_HOLD must fit below 256.
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_check
        $error("bus_arbiter_mux: MAX_HOLD must be in 2..255");
    end

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_preempt0;   // M0 must yield to a waiting M1
    logic       w_preempt1;   // M1 must yield to a waiting M0

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold_cnt;

    assign w_preempt0 = (r_hold_cnt == c_HOLD_LAST) && M1_req;
    assign w_preempt1 = (r_hold_cnt == c_HOLD_LAST) && M0_req;

    // Count consecutive grant cycles; restart on every state change and
    // saturate at the last allowed cycle while nobody else is waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= 8'd0;
        end else if (w_state_nxt != r_state || r_state == c_IDLE) begin
            r_hold_cnt <= 8'd0;
        end else if (r_hold_cnt != c_HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end
`else
    assign w_preempt0 = 1'b0;
    assign w_preempt1 = 1'b0;
`endif

    // Next-state arbitration: M0 wins ties from IDLE, an owner keeps the bus
    // while it requests, and release hands straight over to a waiting master.
    always_comb begin
        w_state_nxt = c_IDLE;
        case (r_state)
            c_IDLE: begin
                if (M0_req)      w_state_nxt = c_GNT0;
                else if (M1_req) w_state_nxt = c_GNT1;
                else             w_state_nxt = c_IDLE;
            end
            c_GNT0: begin
                if (M0_req && !w_preempt0) w_state_nxt = c_GNT0;
                else if (M1_req)           w_state_nxt = c_GNT1;
                else                       w_state_nxt = c_IDLE;
            end
            c_GNT1: begin
                if (M1_req && !w_preempt1) w_state_nxt = c_GNT1;
                else if (M0_req)           w_state_nxt = c_GNT0;
                else                       w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;  // 2'b11 recovers to IDLE
        endcase
    end

    // State register; grants are decoded straight from it, so they are glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_state_nxt;
    end

    assign M0_grant = (r_state == c_GNT0);
    assign M1_grant = (r_state == c_GNT1);
    assign bus_busy = M0_grant | M1_grant;

    // Slave-side mux: only the owner's signals pass; an idle bus is all zero.
    always_comb begin
        S_wr      = 1'b0;
        S_address = '0;
        S_din     = '0;
        case (r_state)
            c_GNT0: begin
                S_wr      = M0_wr;
                S_address = M0_address;
                S_din     = M0_dout;
            end
            c_GNT1: begin
                S_wr      = M1_wr;
                S_address = M1_address;
                S_din     = M1_dout;
            end
            default: begin
                S_wr      = 1'b0;
                S_address = '0;
                S_din     = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_mux.sv
// ============================================================================
//  Module      : tb_bus_arbiter_mux
//  Description : Scoreboard bench for bus_arbiter_mux. Stimulus pushes the
//                expected post-edge outputs into a queue; a monitor pops and
//                compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_mux;

    localparam int c_AW = 8;
    localparam int c_DW = 32;
    localparam int c_K_IDLE = 0;
    localparam int c_K_G0   = 1;
    localparam int c_K_G1   = 2;

    logic            clk;
    logic            reset;
    logic            M0_req, M0_wr, M1_req, M1_wr;
    logic [c_AW-1:0] M0_address, M1_address;
    logic [c_DW-1:0] M0_dout, M1_dout;
    logic            M0_grant, M1_grant, S_wr, bus_busy;
    logic [c_AW-1:0] S_address;
    logic [c_DW-1:0] S_din;

    typedef struct {
        string           tag;
        logic            m0g;
        logic            m1g;
        logic            wr;
        logic [c_AW-1:0] addr;
        logic [c_DW-1:0] din;
        logic            busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bus_arbiter_mux #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW),
        .MAX_HOLD   (4)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .M0_req     (M0_req),
        .M0_wr      (M0_wr),
        .M0_address (M0_address),
        .M0_dout    (M0_dout),
        .M1_req     (M1_req),
        .M1_wr      (M1_wr),
        .M1_address (M1_address),
        .M1_dout    (M1_dout),
        .M0_grant   (M0_grant),
        .M1_grant   (M1_grant),
        .S_wr       (S_wr),
        .S_address  (S_address),
        .S_din      (S_din),
        .bus_busy   (bus_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected outputs: who owns the bus, with the owner's currently driven values.
    function automatic exp_t mk(input string tag, input int kind);
        exp_t e;
        e.tag = tag;
        e.m0g = 1'b0; e.m1g = 1'b0; e.wr = 1'b0; e.addr = '0; e.din = '0; e.busy = 1'b0;
        if (kind == c_K_G0) begin
            e.m0g = 1'b1; e.wr = M0_wr; e.addr = M0_address; e.din = M0_dout; e.busy = 1'b1;
        end else if (kind == c_K_G1) begin
            e.m1g = 1'b1; e.wr = M1_wr; e.addr = M1_address; e.din = M1_dout; e.busy = 1'b1;
        end
        return e;
    endfunction

    // Inputs are already applied (we sit just after a falling edge); expect
    // the result after the coming rising edge, then move to the next slot.
    task automatic step(input string tag, input int kind);
        sb_q.push_back(mk(tag, kind));
        @(negedge clk);
        #1;
    endtask

    // Reset raised just after a rising edge must clear outputs before any
    // further rising edge, i.e. asynchronously.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_q.push_back(mk(tag, c_K_IDLE));
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare outputs against the oldest pending expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            if ({M0_grant, M1_grant, S_wr, S_address, S_din, bus_busy} !==
                {e.m0g, e.m1g, e.wr, e.addr, e.din, e.busy}) begin
                n_fail++;
                $display("FAIL %s: got g0=%b g1=%b wr=%b addr=%h din=%h busy=%b, want g0=%b g1=%b wr=%b addr=%h din=%h busy=%b",
                         e.tag, M0_grant, M1_grant, S_wr, S_address, S_din, bus_busy,
                         e.m0g, e.m1g, e.wr, e.addr, e.din, e.busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        M0_req = 1'b0; M0_wr = 1'b0; M0_address = '0; M0_dout = '0;
        M1_req = 1'b0; M1_wr = 1'b0; M1_address = '0; M1_dout = '0;
        @(negedge clk);
        #1;

        // Reset state, then an idle bus after release.
        step("reset_state", c_K_IDLE);
        reset = 1'b0;
        step("idle_no_req", c_K_IDLE);

        // Single master M1 write.
        M1_req = 1'b1; M1_wr = 1'b1; M1_address = 8'h25; M1_dout = 32'hDEADBEEF;
        step("m1_single_grant", c_K_G1);
        step("m1_single_hold", c_K_G1);
        M1_req = 1'b0;
        step("m1_release_idle", c_K_IDLE);

        // Simultaneous requests from IDLE: M0 wins, then direct handover.
        M0_req = 1'b1; M0_wr = 1'b0; M0_address = 8'h10; M0_dout = 32'h11112222;
        M1_req = 1'b1; M1_wr = 1'b1; M1_address = 8'h3C; M1_dout = 32'hCAFEF00D;
        step("simul_m0_wins", c_K_G0);
        step("simul_m0_hold", c_K_G0);
        M0_req = 1'b0;
        step("handover_0_to_1", c_K_G1);
        M0_req = 1'b1; M1_req = 1'b0;
        step("handover_1_to_0", c_K_G0);

        // Ungranted M1 signals churn while M0 owns the bus.
        M0_wr = 1'b1; M0_address = 8'hA5; M0_dout = 32'h5A5A0F0F;
        for (int i = 0; i < 100; i++) begin
            M1_wr      = 1'($urandom);
            M1_address = 8'($urandom);
            M1_dout    = $urandom;
            step("isolation", c_K_G0);
        end

        // Asynchronous reset mid-transfer, then re-arbitration.
        async_reset("async_reset_mid_xfer");
        M0_address = 8'h42; M0_dout = 32'h01234567;
        reset = 1'b0;
        step("regrant_after_reset", c_K_G0);

        M1_wr = 1'b0; M1_address = 8'h77; M1_dout = 32'h89ABCDEF;
        M1_req = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        // MAX_HOLD=4: four grant cycles, then the waiting master takes over.
        step("to_m0_cycle2", c_K_G0);
        step("to_m0_cycle3", c_K_G0);
        step("to_m0_cycle4", c_K_G0);
        step("to_preempt_m0", c_K_G1);
        step("to_m1_cycle2", c_K_G1);
        step("to_m1_cycle3", c_K_G1);
        step("to_m1_cycle4", c_K_G1);
        step("to_preempt_m1", c_K_G0);
        M1_req = 1'b0;
        for (int i = 0; i < 8; i++) step("to_saturate_hold", c_K_G0);
        M0_req = 1'b0;
        step("to_release_idle", c_K_IDLE);
`else
        // No timeout: M0 keeps the bus however long M1 waits.
        for (int i = 0; i < 22; i++) step("no_timeout_hold", c_K_G0);
        M0_req = 1'b0;
        step("no_timeout_handover", c_K_G1);
        M1_req = 1'b0;
        step("no_timeout_idle", c_K_IDLE);
`endif

        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
